peripheral_bus_hub: RTL and testbench

Parametrised Wishbone-slave-to-peripheral-bus bridge and read-return arbiter for a variable number of peripheral devices. Sits between the Wishbone interconnect and the peripheral blocks (UART, SPI, PWM, GPIO and later additions). Its peripheral-side connections are flattened per-device vectors. It adds several behaviours to the plain interface-plus-priority-mux arrangement:
- registered access state machine
- per-device busy wait
- claim-collision and unmapped-address detection
- optional access timeout

---
 rtl/peripheral_bus_hub.sv | 178 +++++++++++++++++
 tb/tb_peripheral_bus_hub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus_hub.sv
// Wishbone slave to shared peripheral bus bridge with claim-based read return, busy wait and collision flag.
// Optional access timeout is built when PERIPHERAL_HUB_TIMEOUT_EN is defined.
module peripheral_bus_hub #(
    parameter int DEVICE_COUNT   = 4,
    parameter bit UNMAPPED_ERROR = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [3:0]                   wb_sel_i,
    input  logic [23:0]                  wb_adr_i,
    input  logic [31:0]                  wb_data_i,
    output logic                         wb_ack_o,
    output logic                         wb_error_o,
    output logic                         wb_stall_o,
    output logic [31:0]                  wb_data_o,
    output logic                         peripheralBus_we,
    output logic                         peripheralBus_oe,
    output logic [23:0]                  peripheralBus_address,
    output logic [3:0]                   peripheralBus_byteSelect,
    output logic [31:0]                  peripheralBus_dataWrite,
    input  logic [32*DEVICE_COUNT-1:0]   dev_dataRead,
    input  logic [DEVICE_COUNT-1:0]      dev_requestOutput,
    input  logic [DEVICE_COUNT-1:0]      dev_busy,
    output logic                         collision_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    generate
        if (DEVICE_COUNT < 1 || DEVICE_COUNT > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
            $error("peripheral_bus_hub: parameter out of legal range");
        end
    endgenerate

    // 0 = no claim, 1 = exactly one claim, 2 = two or more claims
    function automatic logic [1:0] claim_level(input logic [DEVICE_COUNT-1:0] req);
        logic [1:0] lvl;
        lvl = 2'd0;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            if (req[i] && lvl == 2'd0) lvl = 2'd1;
            else if (req[i])           lvl = 2'd2;
            else                       lvl = lvl;
        end
        return lvl;
    endfunction

    // OR-mux of claiming devices; only meaningful when exactly one device claims
    function automatic logic [31:0] claim_data(input logic [DEVICE_COUNT-1:0] req,
                                               input logic [32*DEVICE_COUNT-1:0] data);
        logic [31:0] d;
        d = 32'h0000_0000;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            if (req[i]) d = d | data[32*i +: 32];
            else        d = d;
        end
        return d;
    endfunction

    state_t      state_r;
    logic [1:0]  claim_lvl_s;
    logic [31:0] claim_data_s;
    logic        busy_any_s;
    logic        timeout_hit_s;

    assign claim_lvl_s  = claim_level(dev_requestOutput);
    assign claim_data_s = claim_data(dev_requestOutput, dev_dataRead);
    assign busy_any_s   = |dev_busy;

`ifdef PERIPHERAL_HUB_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;

    // Access cycle counter: zero on entry to ACCESS, so the Nth ACCESS cycle sees N-1
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_r != ST_ACCESS) tmo_cnt_r <= 16'd0;
        else                                  tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end

    assign timeout_hit_s = (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Access state machine with all bus-facing outputs registered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r                  <= ST_IDLE;
            wb_ack_o                 <= 1'b0;
            wb_error_o               <= 1'b0;
            wb_stall_o               <= 1'b0;
            wb_data_o                <= 32'h0000_0000;
            peripheralBus_we         <= 1'b0;
            peripheralBus_oe         <= 1'b0;
            peripheralBus_address    <= 24'h00_0000;
            peripheralBus_byteSelect <= 4'h0;
            peripheralBus_dataWrite  <= 32'h0000_0000;
            collision_o              <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wb_ack_o   <= 1'b0;
                    wb_error_o <= 1'b0;
                    wb_data_o  <= 32'h0000_0000;
                    if (wb_cyc_i && wb_stb_i) begin
                        peripheralBus_address    <= wb_adr_i;
                        peripheralBus_byteSelect <= wb_sel_i;
                        peripheralBus_dataWrite  <= wb_data_i;
                        peripheralBus_we         <= wb_we_i;
                        peripheralBus_oe         <= !wb_we_i;
                        wb_stall_o               <= 1'b1;
                        state_r                  <= ST_ACCESS;
                    end else begin
                        wb_stall_o <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (!wb_cyc_i) begin
                        peripheralBus_we <= 1'b0;
                        peripheralBus_oe <= 1'b0;
                        wb_stall_o       <= 1'b0;
                        state_r          <= ST_IDLE;
                    end else if (busy_any_s && timeout_hit_s) begin
                        wb_error_o       <= 1'b1;
                        wb_data_o        <= peripheralBus_we ? 32'h0000_0000 : 32'hFFFF_FFFF;
                        peripheralBus_we <= 1'b0;
                        peripheralBus_oe <= 1'b0;
                        state_r          <= ST_RESPOND;
                    end else if (busy_any_s) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        peripheralBus_we <= 1'b0;
                        peripheralBus_oe <= 1'b0;
                        state_r          <= ST_RESPOND;
                        case (claim_lvl_s)
                            2'd1: begin
                                wb_ack_o  <= 1'b1;
                                wb_data_o <= peripheralBus_we ? 32'h0000_0000 : claim_data_s;
                            end
                            2'd0: begin
                                wb_ack_o   <= !UNMAPPED_ERROR;
                                wb_error_o <= UNMAPPED_ERROR;
                                wb_data_o  <= peripheralBus_we ? 32'h0000_0000 : 32'hFFFF_FFFF;
                            end
                            default: begin
                                wb_error_o  <= 1'b1;
                                collision_o <= 1'b1;
                                wb_data_o   <= peripheralBus_we ? 32'h0000_0000 : 32'hFFFF_FFFF;
                            end
                        endcase
                    end
                end
                ST_RESPOND: begin
                    wb_ack_o   <= 1'b0;
                    wb_error_o <= 1'b0;
                    wb_data_o  <= 32'h0000_0000;
                    wb_stall_o <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    wb_ack_o         <= 1'b0;
                    wb_error_o       <= 1'b0;
                    wb_stall_o       <= 1'b0;
                    peripheralBus_we <= 1'b0;
                    peripheralBus_oe <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bus_hub.sv
// Directed scoreboard bench for peripheral_bus_hub; a second instance with UNMAPPED_ERROR = 0 covers unmapped-ack.
module tb_peripheral_bus_hub;
    localparam int NDEV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, cyc, stb, we;
    logic [3:0]         sel;
    logic [23:0]        adr;
    logic [31:0]        wdat;
    logic [32*NDEV-1:0] dev_rd;
    logic [NDEV-1:0]    dev_req, dev_busy;

    logic        ack, err, stall, pwe, poe, coll;
    logic [31:0] rdat, pwdat;
    logic [23:0] paddr;
    logic [3:0]  psel;
    logic        ack2, err2, stall2, pwe2, poe2, coll2;
    logic [31:0] rdat2, pwdat2;
    logic [23:0] paddr2;
    logic [3:0]  psel2;

    peripheral_bus_hub #(.DEVICE_COUNT(NDEV), .UNMAPPED_ERROR(1'b1), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_data_i(wdat),
        .wb_ack_o(ack), .wb_error_o(err), .wb_stall_o(stall), .wb_data_o(rdat),
        .peripheralBus_we(pwe), .peripheralBus_oe(poe), .peripheralBus_address(paddr),
        .peripheralBus_byteSelect(psel), .peripheralBus_dataWrite(pwdat),
        .dev_dataRead(dev_rd), .dev_requestOutput(dev_req), .dev_busy(dev_busy),
        .collision_o(coll));

    peripheral_bus_hub #(.DEVICE_COUNT(NDEV), .UNMAPPED_ERROR(1'b0), .TIMEOUT_CYCLES(8)) dut_ack (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_data_i(wdat),
        .wb_ack_o(ack2), .wb_error_o(err2), .wb_stall_o(stall2), .wb_data_o(rdat2),
        .peripheralBus_we(pwe2), .peripheralBus_oe(poe2), .peripheralBus_address(paddr2),
        .peripheralBus_byteSelect(psel2), .peripheralBus_dataWrite(pwdat2),
        .dev_dataRead(dev_rd), .dev_requestOutput(dev_req), .dev_busy(dev_busy),
        .collision_o(coll2));

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request through the sampling edge; returns in cycle 1 (ACCESS)
    task automatic issue(input logic w, input logic [23:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        step();
        stb = 1'b0;
    endtask

    // Wait (bounded) for ack/error, then compare against the oldest scoreboard entry
    task automatic await_resp(input string tag, input int start_lat);
        int   lat;
        exp_t e;
        lat = start_lat;
        do begin
            step();
            lat++;
        end while (!(ack || err) && lat < 400);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, 32'(lat), 32'(e.lat));
            check({tag, "_ack"}, {31'd0, ack}, {31'd0, e.ack});
            check({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
            check({tag, "_data"}, rdat, e.data);
        end
    endtask

    task automatic finish_txn(input string tag);
        cyc = 1'b0;
        step();
        check({tag, "_one_cycle"}, {30'd0, ack, err}, 32'd0);
        check({tag, "_stall_idle"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        int resp_cnt;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 24'h0; wdat = 32'h0;
        dev_req = 4'b0000; dev_busy = 4'b0000;
        dev_rd = {32'h3333_0003, 32'h2222_0002, 32'hA5A5_0001, 32'h1111_0000};
        step(); step();
        check("rst_outputs", {26'd0, ack, err, stall, pwe, poe, coll}, 32'd0);
        check("rst_rdata", rdat, 32'h0);
        check("rst_addr", {8'd0, paddr}, 32'h0);
        rst = 1'b0;
        step();

        // Read, single claim, zero wait
        dev_req = 4'b0010;
        sb.push_back('{ack: 1'b1, err: 1'b0, data: 32'hA5A5_0001, lat: 2});
        issue(1'b0, 24'h01_0004, 4'hF, 32'h0);
        check("rd_access_strobes", {29'd0, stall, pwe, poe}, 32'b101);
        check("rd_addr", {8'd0, paddr}, 32'h0001_0004);
        await_resp("rd1", 1);
        check("rd1_strobes_low", {30'd0, pwe, poe}, 32'd0);
        finish_txn("rd1");

        // Write with device 2 busy for three ACCESS cycles
        dev_req = 4'b0100; dev_busy = 4'b0100;
        sb.push_back('{ack: 1'b1, err: 1'b0, data: 32'h0, lat: 5});
        issue(1'b1, 24'h02_0010, 4'b0011, 32'hDEAD_BEEF);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) dev_busy = 4'b0000;
            check($sformatf("wr_we_c%0d", c), {30'd0, pwe, poe}, 32'b10);
            check($sformatf("wr_dw_c%0d", c), pwdat, 32'hDEAD_BEEF);
            check($sformatf("wr_sel_c%0d", c), {28'd0, psel}, 32'b0011);
            if (c < 4) step();
        end
        await_resp("wr_busy", 4);
        finish_txn("wr_busy");

        // Unmapped read: error on the default instance, ack on the UNMAPPED_ERROR=0 instance
        dev_req = 4'b0000;
        sb.push_back('{ack: 1'b0, err: 1'b1, data: 32'hFFFF_FFFF, lat: 2});
        issue(1'b0, 24'h0F_0000, 4'hF, 32'h0);
        await_resp("unmapped", 1);
        check("unmapped_alt_resp", {30'd0, ack2, err2}, 32'b10);
        check("unmapped_alt_data", rdat2, 32'hFFFF_FFFF);
        check("unmapped_no_coll", {31'd0, coll}, 32'd0);
        finish_txn("unmapped");

        // Collision between devices 0 and 3; flag must stay sticky
        dev_req = 4'b1001;
        sb.push_back('{ack: 1'b0, err: 1'b1, data: 32'hFFFF_FFFF, lat: 2});
        issue(1'b0, 24'h03_0000, 4'hF, 32'h0);
        await_resp("collision", 1);
        check("collision_flag", {31'd0, coll}, 32'd1);
        finish_txn("collision");
        dev_req = 4'b0000;
        for (int c = 0; c < 10; c++) step();
        check("collision_sticky", {31'd0, coll}, 32'd1);

        // Abort: cyc dropped during the second busy cycle
        dev_req = 4'b0010; dev_busy = 4'b0010;
        issue(1'b0, 24'h01_0008, 4'hF, 32'h0);
        step();
        cyc = 1'b0;
        step();
        check("abort_idle", {28'd0, ack, err, stall, pwe | poe}, 32'd0);
        resp_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (ack || err) resp_cnt++;
        end
        check("abort_no_resp", 32'(resp_cnt), 32'd0);
        dev_busy = 4'b0000;
        sb.push_back('{ack: 1'b1, err: 1'b0, data: 32'hA5A5_0001, lat: 2});
        issue(1'b0, 24'h01_0004, 4'hF, 32'h0);
        await_resp("after_abort", 1);
        finish_txn("after_abort");

        // Reset in the middle of a busy write
        dev_req = 4'b0100; dev_busy = 4'b0100;
        issue(1'b1, 24'h12_3456, 4'hC, 32'hCAFE_F00D);
        check("mid_rst_pre_we", {31'd0, pwe}, 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_ctrl", {26'd0, ack, err, stall, pwe, poe, coll}, 32'd0);
        check("mid_rst_addr", {4'd0, psel, paddr}, 32'd0);
        check("mid_rst_wdata", pwdat, 32'd0);
        check("mid_rst_rdata", rdat, 32'd0);
        rst = 1'b0; cyc = 1'b0; dev_busy = 4'b0000;
        step();

        // Permanently busy device: timeout error when built, else no response at all
        dev_req = 4'b0001; dev_busy = 4'b0001;
`ifdef PERIPHERAL_HUB_TIMEOUT_EN
        sb.push_back('{ack: 1'b0, err: 1'b1, data: 32'hFFFF_FFFF, lat: 9});
        issue(1'b0, 24'h00_0020, 4'hF, 32'h0);
        await_resp("timeout", 1);
        cyc = 1'b0;
        resp_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ack || err) resp_cnt++;
        end
        check("timeout_no_more", 32'(resp_cnt), 32'd0);
`else
        issue(1'b0, 24'h00_0020, 4'hF, 32'h0);
        resp_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (ack || err) resp_cnt++;
        end
        check("no_timeout_resp", 32'(resp_cnt), 32'd0);
        check("no_timeout_oe", {31'd0, poe}, 32'd1);
        cyc = 1'b0;
        step();
        check("no_timeout_abort", {29'd0, stall, pwe, poe}, 32'd0);
`endif
        dev_busy = 4'b0000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
